maxpool2d: RTL and testbench
============================

# maxpool2d

Streaming 2x2, stride-2 max-pooling stage placed directly downstream of `conv2d`. It consumes the signed raster-order accumulator stream that `conv2d` produces, one sample per input handshake, and emits one pooled sample per 2x2 input block. An optional ReLU is fused into the output. A one-deep elastic output register provides ready/valid backpressure toward the upstream stage.

## Interface

- `LineWidthPx`, 158: samples per input row; this is the conv2d output row length, `160-3+1`.
- `LineCountPx`, 118: rows per input frame.
- `Width`, 32: signed sample width, used for both input and output.
- `ReluEn`, 0: when 1, the output is `max(pool, 0)`.
- `clk_i`  in  1  single clock; all state is updated on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `valid_i`  in  1  input sample valid.
- `ready_o`  out  1  stage can accept an input.
- `data_i`  in  `Width`  signed input sample, raster order.
- `valid_o`  out  1  pooled sample valid.
- `ready_i`  in  1  downstream accepts the output.
- `data_o`  out  `Width`  signed pooled sample.

## Operation

- `in_fire = valid_i & ready_o`. `out_fire = valid_o & ready_i`.
- Counters `x` (0..LineWidthPx-1) and `y` (0..LineCountPx-1) advance on `in_fire` only.
  - At `x = LineWidthPx-1`, `x` wraps to 0 and `y` increments.
  - At the last sample of the frame, both counters wrap to 0. Frames run back-to-back with no gap state.
- Pool columns: `PoolCols = LineWidthPx/2`. Pool rows: `LineCountPx/2` (both floor).
- Samples with `x >= 2*PoolCols` or `y >= 2*(LineCountPx/2)` are the odd trailing column or row. They are accepted and discarded: no buffer write, no output.
- Horizontal pair register `h_r`:
  - On even `x`, `h_r <= data_i`.
  - On odd `x`, the pair max is `hmax = max(h_r, data_i)`. The comparison is signed.
- Row buffer `rowbuf[PoolCols]` of `Width` bits:
  - Even `y`, odd `x`: `rowbuf[x>>1] <= hmax`.
  - Odd `y`, odd `x`: the pooled value is `p = max(hmax, rowbuf[x>>1])`. This is a produce event.
- Output value is `p` when `ReluEn=0`. When `ReluEn=1`, the output is `p` if `p > 0`, else 0.
- Elastic output register:
  - `ready_o = ~valid_r | ready_i`.
  - When `ready_o` is high: `valid_r <= produce`, and on produce `data_r <= out value`.
  - `data_o` holds its value whenever `valid_r` is high and `ready_i` is low.
- Reset values: `valid_o=0`, `data_o=0`, `x=y=0`, `h_r=0`. `rowbuf` contents are don't-care, because an even row always rewrites every entry before it is read.
- Reset mid-frame restarts at pixel (0,0) on the first fire after release. Partial pool results are lost.

## Timing

- Latency: a produce `in_fire` in cycle N gives `valid_o=1` and a valid `data_o` in cycle N+1.
- Throughput: 1 input per cycle while `ready_i=1`. Output rate is at most 1 per 4 inputs, bursty: 1 per 2 inputs during odd rows.
- Backpressure:
  - While `valid_o=1` and `ready_i=0`, `ready_o=0`, so no input is lost.
  - Simultaneous `out_fire` and a new produce loads the next value in the same cycle. There is no bubble.
- Combinational path is from `ready_i` to `ready_o` only. No combinational path exists from `data_i` to `data_o`.
- `rowbuf` read and write for the same index never occur in the same cycle, since reads and writes happen in different row parities. A register array with one write port and one read port suffices.

## Structure

- Shared package `vision_pkg`:
  - `function pool_dim(int n)`, returning `n/2`, so the next stage can size its own `LineWidthPx` and `LineCountPx`.
  - `localparam PoolSize = 2`.
- Sub-module `pool_row_buffer`: a parameterised `Depth`x`Width` register array with a synchronous write, an asynchronous read, and write enable. Everything else, including counters, compare logic, ReLU and the elastic register, is inline. Expected size is about 150-250 lines.

## Test plan

- **4x4 ramp.** `LineWidthPx=4`, `LineCountPx=4`, inputs 0..15 in raster order, `ready_i=1` -> outputs 5, 7, 13, 15. Each `valid_o` appears one cycle after inputs 5, 7, 13 and 15 fire.
- **Signed and ReLU.** 4x4 frame of all -3 -> `ReluEn=0` gives four outputs of -3. `ReluEn=1` gives four outputs of 0. A single value of +9 at (1,1) -> first output is 9 in both modes.
- **Odd dimensions.** `LineWidthPx=5`, `LineCountPx=5`, inputs 0..24 -> exactly 4 outputs: 6, 8, 16, 18. All 25 inputs are accepted, and the next frame starts cleanly.
- **Backpressure.** 4x4 ramp with `ready_i=0` for 5 cycles after the first `valid_o` -> `data_o` holds 5, `ready_o=0` throughout, and no input is dropped. The output sequence is unchanged.
- **Reset mid-frame.** Assert `rst_i` asynchronously after 6 inputs -> `valid_o` and `data_o` go to 0 immediately. A following full ramp frame yields 5, 7, 13, 15.
- **Back-to-back frames.** Two consecutive 4x4 ramps with `valid_i` held high -> 8 outputs, with the second frame's values identical to the first.

Source files
------------

// File: rtl/vision_pkg.sv
// vision_pkg: constants and helpers shared by the vision pipeline stages.
// pool_dim() lets a downstream stage size itself from the pooled geometry.
package vision_pkg;

  localparam int PoolSize = 2;

  function automatic int pool_dim(input int n);
    return n / PoolSize;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// pool_row_buffer: Depth x Width register array.
// Synchronous write, asynchronous read, no reset on contents.
module pool_row_buffer #(
  parameter int Depth = 79,
  parameter int Width = 32,
  localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] r_mem [Depth];

  // store the horizontal pair max of an even row
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/maxpool2d.sv
// maxpool2d: streaming 2x2 stride-2 max pool with optional fused ReLU.
// One-deep elastic output register; trailing odd column/row is dropped.
module maxpool2d
  import vision_pkg::*;
#(
  parameter int LineWidthPx = 158,
  parameter int LineCountPx = 118,
  parameter int Width       = 32,
  parameter bit ReluEn      = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  localparam int PoolCols = pool_dim(LineWidthPx);
  localparam int PoolRows = pool_dim(LineCountPx);
  localparam int XW = $clog2(LineWidthPx);
  localparam int YW = $clog2(LineCountPx);
  localparam int CW = (PoolCols > 1) ? $clog2(PoolCols) : 1;

  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [Width-1:0] r_h;
  logic             r_valid;
  logic [Width-1:0] r_data;

  logic             w_in_fire;
  logic             w_x_last;
  logic             w_y_last;
  logic             w_in_pool;
  logic             w_we;
  logic             w_produce;
  logic [CW-1:0]    w_col;
  logic [Width-1:0] w_hmax;
  logic [Width-1:0] w_rd;
  logic [Width-1:0] w_pool;
  logic [Width-1:0] w_out;

  assign ready_o   = ~r_valid | ready_i;
  assign w_in_fire = valid_i & ready_o;
  assign w_x_last  = (r_x == XW'(LineWidthPx - 1));
  assign w_y_last  = (r_y == YW'(LineCountPx - 1));
  assign w_in_pool = (int'(r_x) < 2 * PoolCols) &&
                     (int'(r_y) < 2 * PoolRows);
  assign w_col     = CW'(r_x >> 1);
  assign w_we      = w_in_fire & w_in_pool & r_x[0] & ~r_y[0];
  assign w_produce = w_in_fire & w_in_pool & r_x[0] & r_y[0];

  assign w_hmax = ($signed(data_i) > $signed(r_h)) ? data_i : r_h;
  assign w_pool = ($signed(w_rd) > $signed(w_hmax)) ? w_rd : w_hmax;
  assign w_out  = (ReluEn && !($signed(w_pool) > 0)) ? '0 : w_pool;

  pool_row_buffer #(
    .Depth (PoolCols),
    .Width (Width)
  ) u_rowbuf (
    .clk_i   (clk_i),
    .we_i    (w_we),
    .waddr_i (w_col),
    .wdata_i (w_hmax),
    .raddr_i (w_col),
    .rdata_o (w_rd)
  );

  // raster position of the next accepted sample
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_in_fire) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // hold the left sample of each horizontal pair
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_h <= '0;
    end else if (w_in_fire && w_in_pool && !r_x[0]) begin
      r_h <= data_i;
    end
  end

  // elastic output register, stalls input while full and blocked
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (ready_o) begin
      r_valid <= w_produce;
      if (w_produce) begin
        r_data <= w_out;
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;

endmodule

// File: tb/tb_maxpool2d.sv
// tb_maxpool2d: directed vector table plus hand-written
// backpressure and mid-frame reset sequences.
module tb_maxpool2d;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_i;
  logic [31:0] data_i;

  logic        a_ready, a_valid;
  logic [31:0] a_data;
  logic        r_ready, r_valid;
  logic [31:0] r_data;
  logic        o_ready, o_valid;
  logic [31:0] o_data;

  logic        s_ready, s_valid;
  logic [31:0] s_data;
  int          sel;

  always #5 clk = ~clk;

  maxpool2d #(
    .LineWidthPx (4), .LineCountPx (4), .Width (32), .ReluEn (1'b0)
  ) u_a (
    .clk_i (clk), .rst_i (rst), .valid_i (valid_i), .ready_o (a_ready),
    .data_i (data_i), .valid_o (a_valid), .ready_i (ready_i), .data_o (a_data)
  );

  maxpool2d #(
    .LineWidthPx (4), .LineCountPx (4), .Width (32), .ReluEn (1'b1)
  ) u_r (
    .clk_i (clk), .rst_i (rst), .valid_i (valid_i), .ready_o (r_ready),
    .data_i (data_i), .valid_o (r_valid), .ready_i (ready_i), .data_o (r_data)
  );

  maxpool2d #(
    .LineWidthPx (5), .LineCountPx (5), .Width (32), .ReluEn (1'b0)
  ) u_o (
    .clk_i (clk), .rst_i (rst), .valid_i (valid_i), .ready_o (o_ready),
    .data_i (data_i), .valid_o (o_valid), .ready_i (ready_i), .data_o (o_data)
  );

  always_comb begin
    s_ready = a_ready;
    s_valid = a_valid;
    s_data  = a_data;
    if (sel == 1) begin
      s_ready = r_ready;
      s_valid = r_valid;
      s_data  = r_data;
    end else if (sel == 2) begin
      s_ready = o_ready;
      s_valid = o_valid;
      s_data  = o_data;
    end
  end

  typedef struct {
    string            name;
    int               sel;
    int               pat;
    int               w;
    int               h;
    int               frames;
    int               nexp;
    logic [7:0][31:0] exp;
  } vec_t;

  vec_t vecs[7];
  int   pix[64];
  int   got[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vmask;
  int   bp_bad;
  int   bp_cyc;
  int   hold_exp;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pat, input int w, input int h, input int fr);
    for (int f = 0; f < fr; f++) begin
      for (int i = 0; i < w * h; i++) begin
        case (pat)
          0:       pix[f*w*h+i] = i;
          1:       pix[f*w*h+i] = -3;
          default: pix[f*w*h+i] = (i == w + 1) ? 9 : -3;
        endcase
      end
    end
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // entered and left at posedge+1
  task automatic run(input int lim, input int bp, input int tail_max,
                     output int acc);
    int  idx = 0;
    int  bpc = 0;
    int  tail = 0;
    int  cyc = 0;
    bit  bp_done = 1'b0;
    got.delete();
    vmask  = 0;
    bp_bad = 0;
    bp_cyc = 0;
    while (1) begin
      if (bp != 0 && !bp_done && s_valid) begin
        bp_done = 1'b1;
        bpc = 5;
      end
      ready_i = (bpc == 0);
      valid_i = (idx < lim);
      data_i  = valid_i ? pix[idx] : '0;
      @(negedge clk);
      if (cyc < 32) vmask[cyc] = s_valid;
      if (bpc > 0) begin
        bp_cyc++;
        if (s_ready || !s_valid || $signed(s_data) != hold_exp) bp_bad++;
      end
      if (s_valid && ready_i) got.push_back($signed(s_data));
      if (valid_i && s_ready) idx++;
      if (bpc > 0) bpc--;
      @(posedge clk);
      #1;
      cyc++;
      if (idx >= lim) begin
        if (tail >= tail_max) break;
        tail++;
      end
      if (cyc > 400) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout: accepted %0d required %0d", idx, lim);
        break;
      end
    end
    valid_i = 1'b0;
    acc = idx;
  endtask

  initial begin
    int acc;
    int n;
    vecs[0] = '{"ramp4", 0, 0, 4, 4, 1, 4, {32'd0, 32'd0, 32'd0, 32'd0,
                32'd15, 32'd13, 32'd7, 32'd5}};
    vecs[1] = '{"neg3", 0, 1, 4, 4, 1, 4, {32'd0, 32'd0, 32'd0, 32'd0,
                -32'sd3, -32'sd3, -32'sd3, -32'sd3}};
    vecs[2] = '{"neg3_relu", 1, 1, 4, 4, 1, 4, {32'd0, 32'd0, 32'd0,
                32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
    vecs[3] = '{"spike", 0, 2, 4, 4, 1, 4, {32'd0, 32'd0, 32'd0, 32'd0,
                -32'sd3, -32'sd3, -32'sd3, 32'd9}};
    vecs[4] = '{"spike_relu", 1, 2, 4, 4, 1, 4, {32'd0, 32'd0, 32'd0,
                32'd0, 32'd0, 32'd0, 32'd0, 32'd9}};
    vecs[5] = '{"odd5x2", 2, 0, 5, 5, 2, 8, {32'd18, 32'd16, 32'd8, 32'd6,
                32'd18, 32'd16, 32'd8, 32'd6}};
    vecs[6] = '{"b2b4", 0, 0, 4, 4, 2, 8, {32'd15, 32'd13, 32'd7, 32'd5,
                32'd15, 32'd13, 32'd7, 32'd5}};
    hold_exp = 5;

    for (int v = 0; v < 7; v++) begin
      sel = vecs[v].sel;
      do_reset();
      #1;
      chk({vecs[v].name, "_rst_valid"}, int'(s_valid), 0);
      chk({vecs[v].name, "_rst_data"}, $signed(s_data), 0);
      chk({vecs[v].name, "_rst_ready"}, int'(s_ready), 1);
      fill(vecs[v].pat, vecs[v].w, vecs[v].h, vecs[v].frames);
      n = vecs[v].w * vecs[v].h * vecs[v].frames;
      run(n, 0, 4, acc);
      chk({vecs[v].name, "_accepted"}, acc, n);
      chk({vecs[v].name, "_count"}, got.size(), vecs[v].nexp);
      for (int k = 0; k < vecs[v].nexp && k < got.size(); k++)
        chk($sformatf("%s_out%0d", vecs[v].name, k), got[k],
            $signed(vecs[v].exp[k]));
      if (v == 0) chk("ramp4_valid_timing", vmask, 32'h0001_4140);
    end

    // backpressure: hold first output for 5 cycles
    sel = 0;
    do_reset();
    fill(0, 4, 4, 1);
    run(16, 1, 4, acc);
    chk("bp_cycles", bp_cyc, 5);
    chk("bp_hold_bad", bp_bad, 0);
    chk("bp_accepted", acc, 16);
    chk("bp_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++)
      chk($sformatf("bp_out%0d", k), got[k], (k < 2) ? 5 + 2 * k : 9 + 2 * k);

    // reset asserted mid-frame while an output is pending
    sel = 0;
    do_reset();
    fill(0, 4, 4, 1);
    run(6, 0, 0, acc);
    ready_i = 1'b0;
    chk("mid_pre_valid", int'(s_valid), 1);
    chk("mid_pre_data", $signed(s_data), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(s_valid), 0);
    chk("mid_rst_data", $signed(s_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_i = 1'b1;
    run(16, 0, 4, acc);
    chk("mid_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++)
      chk($sformatf("mid_out%0d", k), got[k], (k < 2) ? 5 + 2 * k : 9 + 2 * k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
